// File: rtl/serial_to_parallel_pkg.sv
// Shared constants for the serial-to-parallel converter.
// Holds the default word width, counter width and bit-order encoding.
// No logic; imported by the converter and its bit counter.
package serial_to_parallel_pkg;

  // Default assembled word width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // Counter width needed for the default word width.
  localparam int CNT_W = $clog2(WIDTH_DEFAULT);

  // Bit-order encoding as seen on the msb_first input.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } mode_e;

  // Counter width for an arbitrary word width (0..w-1 must fit).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_to_parallel_bit_counter.sv
// Bit position counter: counts accepted bits 0..WIDTH-1 and wraps on the last.
// Latency: count updates on the clock edge; wrap is combinational from inc/count.
// Backpressure: none; every inc is counted, clr wins over inc.
module bit_counter
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic last;

  assign last = (count == CW'(WIDTH - 1));
  assign wrap = inc && !clr && last;

  // Advance on each accepted bit, returning to zero after the WIDTH-th.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: assembles WIDTH serial bits into a word, LSB- or MSB-first.
// Latency: word appears on out one cycle after its last bit is accepted.
// Backpressure: out holds until out_ready; a word completing while out is blocked is dropped and flagged.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             msb_first,
  input  logic             flush,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]    count;
  logic             wrap;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  mode_e            mode_q;
  mode_e            mode_cur;
  logic             accept;
  logic             transfer;

  assign accept   = in_valid && !flush;
  assign transfer = out_valid && out_ready;

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .inc   (accept),
    .count (count),
    .wrap  (wrap)
  );

  // Bit order comes from the input on a word's first bit, from the latch afterwards.
  always_comb begin
    mode_cur  = (count == '0) ? mode_e'(msb_first) : mode_q;
    shreg_nxt = shreg;
    if (mode_cur == MSB_FIRST) begin
      shreg_nxt = {shreg[WIDTH-2:0], in};
    end else begin
      shreg_nxt = {in, shreg[WIDTH-1:1]};
    end
  end

  // Shift in accepted bits and hold the bit order for the rest of the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      mode_q <= LSB_FIRST;
    end else if (flush) begin
      shreg  <= '0;
    end else if (accept) begin
      shreg  <= shreg_nxt;
      mode_q <= mode_cur;
    end
  end

  // Output register: load on completion if free or draining, else drop and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wrap && (!out_valid || transfer)) begin
        out       <= shreg_nxt;
        out_valid <= 1'b1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
      if (flush) begin
        overrun <= 1'b0;
      end else if (wrap && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  // busy mirrors (count != 0) of the updated counter.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= 1'b0;
    end else if (accept) begin
      busy <= !wrap;
    end
  end

endmodule
